// File: rtl/dec_grant_arbiter.sv
// Purpose: round-robin owner of a shared 4-to-16 select decoder among 16 requesters; optional forced release under `GRANT_TIMEOUT_EN.
// Latency: request sampled in IDLE -> grant registered one cycle later; at least one IDLE cycle between grants.
// Backpressure: owner holds the grant while its req stays high; en low blocks new grants but never revokes a live one.
module dec_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_oh,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [3:0]  pick_idx;
    logic        pick_vld;
    logic        owner_req;
    logic        hold_expired;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("dec_grant_arbiter: MAX_HOLD must be within 1..255");
    end

    // First set request at or above ptr, wrapping 15 -> 0.
    always_comb begin
        pick_idx = ptr;
        pick_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!pick_vld && req[ptr + 4'(i)]) begin
                pick_idx = ptr + 4'(i);
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_req = req[grant_idx];

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // hold_cnt counts completed GRANT cycles; the MAX_HOLD-th edge forces release.
    assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                hold_cnt <= 8'd0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
                if (owner_req && hold_expired) begin
                    timeout <= 1'b1;
                end
            end
        end
    end
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 4'd0;
            grant_idx   <= 4'd0;
            grant_valid <= 1'b0;
            grant_oh    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_vld) begin
                        state       <= GRANT;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        grant_oh    <= 16'd1 << pick_idx;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_expired) begin
                        state       <= IDLE;
                        ptr         <= grant_idx + 4'd1;
                        grant_valid <= 1'b0;
                        grant_oh    <= 16'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_grant_arbiter.sv
// Directed plus randomized bench for dec_grant_arbiter against a spec-level arbitration model.
module tb_dec_grant_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] req = 16'd0;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_oh;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the resource, whose turn is next, how long the grant has lasted.
    bit m_busy;
    int m_owner;
    int m_next;
    int m_held;
    bit m_tmo;

    dec_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_next  = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [15:0] r, input logic e);
        m_tmo = 1'b0;
        if (!m_busy) begin
            if (e && r != 16'd0) begin
                for (int k = 0; k < 16; k++) begin
                    if (r[(m_next + k) % 16]) begin
                        m_owner = (m_next + k) % 16;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_held = 0;
            end
        end else begin
            m_held++;
            if (!r[m_owner]) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % 16;
            end
`ifdef GRANT_TIMEOUT_EN
            else if (m_held >= MAX_HOLD) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % 16;
                m_tmo  = 1'b1;
            end
`endif
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [15:0] exp_oh;
        exp_oh = 16'd0;
        if (m_busy) exp_oh[m_owner] = 1'b1;
        check({tag, "_valid"}, {15'd0, grant_valid}, {15'd0, m_busy});
        check({tag, "_idx"},   {12'd0, grant_idx},   16'(m_owner));
        check({tag, "_oh"},    grant_oh,             exp_oh);
        check({tag, "_tmo"},   {15'd0, timeout},     {15'd0, m_tmo});
    endtask

    // Called at a negedge: drive inputs, take one edge, check, return at next negedge.
    task automatic step(input string tag, input logic [15:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        req   = 16'd0;
        rst_n = 1'b1;
    endtask

    initial begin
        int          idx2_cycles;
        bit          saw_tmo;
        bit          saw_idx8;
        logic [15:0] rr;
        logic [3:0]  rot_exp [4];
        logic [15:0] rot_rel [4];

        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-grant with owner 9
        step("g9", 16'h0200, 1'b1);
        check("g9_idx", {12'd0, grant_idx}, 16'd9);
        step("g9_hold", 16'h0200, 1'b1);
        do_reset("rst_mid");
        step("after_rst", 16'h0001, 1'b1);
        check("after_rst_idx", {12'd0, grant_idx}, 16'd0);
        step("after_rst_rel", 16'h0000, 1'b1);

        // Single requester and pointer advance
        do_reset("rst_single");
        step("single", 16'h0020, 1'b1);
        check("single_idx", {12'd0, grant_idx}, 16'd5);
        check("single_oh", grant_oh, 16'h0020);
        step("single_hold", 16'h0020, 1'b1);
        step("single_rel", 16'h0000, 1'b1);
        check("single_rel_valid", {15'd0, grant_valid}, 16'd0);
        step("ptr6", 16'hFFFF, 1'b1);
        check("ptr6_idx", {12'd0, grant_idx}, 16'd6);
        step("ptr6_rel", 16'h0000, 1'b1);

        // Rotation over 16'h8003, two grant cycles per owner, one idle cycle between
        do_reset("rst_rot");
        rot_exp = '{4'd0, 4'd1, 4'd15, 4'd0};
        rot_rel = '{16'h8002, 16'h8001, 16'h0003, 16'h8002};
        for (int g = 0; g < 4; g++) begin
            step("rot_grant", 16'h8003, 1'b1);
            check($sformatf("rot_idx%0d", g), {12'd0, grant_idx}, {12'd0, rot_exp[g]});
            step("rot_hold", 16'h8003, 1'b1);
            step("rot_rel", rot_rel[g], 1'b1);
            check($sformatf("rot_gap%0d", g), {15'd0, grant_valid}, 16'd0);
        end

        // Wrap: release at 14 leaves ptr at 15
        step("w14", 16'h4000, 1'b1);
        check("w14_idx", {12'd0, grant_idx}, 16'd14);
        step("w14_rel", 16'h0000, 1'b1);
        step("w15", 16'h8001, 1'b1);
        check("w15_idx", {12'd0, grant_idx}, 16'd15);
        step("w15_rel", 16'h0001, 1'b1);
        step("w0", 16'h8001, 1'b1);
        check("w0_idx", {12'd0, grant_idx}, 16'd0);
        step("w0_rel", 16'h0000, 1'b1);

        // Enable blocks new grants only
        for (int i = 0; i < 10; i++) step("en_off", 16'hFFFF, 1'b0);
        check("en_off_valid", {15'd0, grant_valid}, 16'd0);
        step("en_on", 16'hFFFF, 1'b1);
        check("en_on_idx", {12'd0, grant_idx}, 16'd1);
        step("en_drop", 16'hFFFF, 1'b0);
        step("en_drop2", 16'hFFFF, 1'b0);
        check("en_drop_valid", {15'd0, grant_valid}, 16'd1);
        step("en_rel", 16'hFFFD, 1'b0);
        step("en_idle", 16'hFFFF, 1'b0);

        // Hold limit: 16'h0104 held continuously
        do_reset("rst_tmo");
        idx2_cycles = 0;
        saw_tmo     = 1'b0;
        saw_idx8    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step("tmo", 16'h0104, 1'b1);
            if (grant_valid && grant_idx == 4'd2) idx2_cycles++;
            if (timeout) saw_tmo = 1'b1;
            if (grant_valid && grant_idx == 4'd8) saw_idx8 = 1'b1;
        end
`ifdef GRANT_TIMEOUT_EN
        check("tmo_hold_len", 16'(idx2_cycles), 16'd4);
        check("tmo_seen", {15'd0, saw_tmo}, 16'd1);
        check("tmo_next8", {15'd0, saw_idx8}, 16'd1);
`else
        check("tmo_hold_len", 16'(idx2_cycles), 16'd8);
        check("tmo_seen", {15'd0, saw_tmo}, 16'd0);
        check("tmo_next8", {15'd0, saw_idx8}, 16'd0);
`endif
        step("tmo_rel", 16'h0000, 1'b1);
        step("tmo_idle", 16'h0000, 1'b1);

        // Owner drops exactly on the cycle the hold limit is reached: normal release
        do_reset("rst_edge");
        for (int i = 0; i < 4; i++) step("edge_hold", 16'h0004, 1'b1);
        step("edge_rel", 16'h0000, 1'b1);
        check("edge_rel_tmo", {15'd0, timeout}, 16'd0);
        check("edge_rel_valid", {15'd0, grant_valid}, 16'd0);

        // Randomized traffic: slowly toggling request bits, occasional enable drops
        rr = 16'd0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            end
            step("rand", rr, ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dec_grant_arbiter.md
# dec_grant_arbiter

Round-robin arbiter that shares one 4-to-16 select decoder, and the resource it addresses, among 16 requesters. It holds the 4-bit index of the current owner, drives the matching one-hot select, and sequences ownership hand-over with a fixed idle gap between grants. It sits between the requester bank and the decoder-driven write/select fabric.

## Interface
- `MAX_HOLD`, default 8: cycles a grant may be held before forced release; used only with `GRANT_TIMEOUT_EN`; legal range 1..255.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: arbitration enable; low blocks new grants only.
- `req` input 16: request vector; `req[k]` held high by requester k for as long as it wants or uses the resource.
- `grant_valid` output 1: a grant is active.
- `grant_idx` output 4: index of the owner; feeds the decoder select.
- `grant_oh` output 16: one-hot grant; `grant_oh[k]` = 1 iff `grant_valid` and `grant_idx` == k.
- `timeout` output 1: one-cycle pulse on forced release.

## Operation
- The FSM has two states: IDLE and GRANT.
- **IDLE:**
  - `grant_valid` = 0, `grant_oh` = 0. `grant_idx` holds the last owner, or 0 after reset.
  - At an edge with `en` = 1 and `req` != 0: select the first set `req` bit searching upward from `ptr`, wrapping 15 -> 0. Load it into `grant_idx` and go to GRANT.
  - `en` = 0 or `req` = 0: stay in IDLE.
- **GRANT:**
  - `grant_valid` = 1 and `grant_oh` is decoded from `grant_idx`.
  - At an edge where `req[grant_idx]` = 0: go to IDLE and set `ptr` = `grant_idx` + 1 mod 16 (4-bit wrap, 15 -> 0).
  - Other `req` bits are ignored while in GRANT.
  - `en` falling during GRANT does not revoke the grant.
- **Pointer:** 4-bit `ptr` changes only on release. After a grant to k, requester k has the lowest priority at the next arbitration.
- **Reset** (any time, including mid-grant): state IDLE, `ptr` = 0, `grant_idx` = 0, `grant_valid` = 0, `grant_oh` = 0, `timeout` = 0, hold counter = 0. No grant survives reset.
- **Starvation freedom:** each requester that keeps `req` high is granted within 15 intervening grants.

## Timing
- Request to grant: `req` high and sampled at edge N in IDLE gives `grant_valid` = 1 after edge N, i.e. one cycle of latency.
- Release to idle: `req[owner]` low sampled at edge M gives `grant_valid` = 0 after edge M.
- Minimum gap between consecutive grants is one IDLE cycle, even with other requests pending. Back-to-back grants are therefore every 2 cycles at best.
- A requester that drops and re-raises `req` in the same IDLE cycle competes normally from its new, lowest priority.
- All outputs are registered or decoded only from registered state; there is no combinational path from `req` or `en` to any output.

## Configuration
- **Macro `GRANT_TIMEOUT_EN` defined:**
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches `MAX_HOLD` with `req[owner]` still high, the arbiter forces release: go to IDLE, advance `ptr` as for a normal release, and assert `timeout` for exactly one cycle, coincident with the first IDLE cycle.
  - A grant therefore lasts at most `MAX_HOLD` cycles.
  - The same owner may win again in the next arbitration only if no other bit of `req` is set.
  - A normal release on the same edge the count reaches `MAX_HOLD` is a normal release: `timeout` stays 0.
- **Macro not defined:** no counter is built, `timeout` is tied 0, and a grant lasts until the owner drops `req`.

## Test plan
- Reset: assert `rst_n` = 0 mid-grant with `grant_idx` = 9 -> immediately `grant_valid` = 0, `grant_oh` = 0, `grant_idx` = 0; after release, `req` = 16'h0001 is granted index 0 one cycle later.
- Single requester: `req` = 16'h0020 -> `grant_idx` = 5 and `grant_oh` = 16'h0020 one cycle later; drop `req[5]` -> `grant_valid` = 0 next cycle, and `ptr` = 6 when checked by the next arbitration.
- Rotation: `req` = 16'h8003 held, each owner releasing after 2 grant cycles -> grant order 0, 1, 15, 0, with exactly one idle cycle between grants.
- Wrap: `ptr` = 15 after a release at index 14, then `req` = 16'h8001 -> grant 15 first, then 0.
- Enable: `en` = 0 with `req` = 16'hFFFF -> no grant for 10 cycles; raise `en` -> grant index equal to `ptr` one cycle later; lowering `en` mid-grant keeps the grant.
- Timeout (macro on, `MAX_HOLD` = 4): `req` = 16'h0104 held -> index 2 granted for 4 cycles, then forced release, `timeout` high for 1 cycle, and index 8 granted the cycle after. With the macro off, index 2 holds indefinitely and `timeout` stays 0.
